// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/ack bus and the decode handshake, as seen from the fetch sequencer.
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        dec_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output instr_valid,
        input  dec_ready,
        output instr_out,
        output instr_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  instr_valid,
        output dec_ready,
        input  instr_out,
        input  instr_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter owner for the MIPS core: one outstanding instruction fetch at a time,
// branch/jump/jr redirects with stale-fetch kill, fetch timeout and jr alignment detection.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 16,
    parameter int          TO_W     = 8
) (
    input  logic                Clk,
    input  logic                PcReSet,
    fetch_sequencer_if.master   bus,
    input  logic [31:0]         ex_pc,
    input  logic                br_taken,
    input  logic [15:0]         br_off,
    input  logic                j_valid,
    input  logic [25:0]         j_index,
    input  logic                jr_valid,
    input  logic [31:0]         jr_addr,
    output logic                align_err,
    output logic                bus_err
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [31:0]       pc, pc_nxt;
    logic [31:0]       fetch_addr, fetch_addr_nxt;
    logic [31:0]       instr_out_r, instr_pc_r;
    logic              kill, kill_nxt;
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
    logic              ld_instr;
    logic              bus_err_nxt;
    logic              align_err_nxt;

    logic              redir;
    logic [31:0]       redir_target;
    logic              to_expire;

    function automatic logic [31:0] br_target(input logic [31:0] epc,
                                              input logic signed [15:0] off);
        logic signed [31:0] disp;
        disp = {{14{off[15]}}, off, 2'b00};
        return epc + 32'd4 + $unsigned(disp);
    endfunction

    function automatic logic [31:0] j_target(input logic [31:0] epc,
                                             input logic [25:0] idx);
        logic [31:0] p4;
        p4 = epc + 32'd4;
        return {p4[31:28], idx, 2'b00};
    endfunction

    // Redirect selection: jr beats j beats br; nothing redirects a machine stuck in ERR.
    always_comb begin
        redir = (state != ERR) && (jr_valid || j_valid || br_taken);
        if (jr_valid)
            redir_target = {jr_addr[31:2], 2'b00};
        else if (j_valid)
            redir_target = j_target(ex_pc, j_index);
        else
            redir_target = br_target(ex_pc, br_off);
        to_expire     = (to_cnt == TO_W'(TIMEOUT - 1));
        align_err_nxt = (state != ERR) && jr_valid && (jr_addr[1:0] != 2'b00);
    end

    always_ff @(posedge Clk or posedge PcReSet) begin
        if (PcReSet)
            state <= BOOT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        fetch_addr_nxt = fetch_addr;
        kill_nxt       = kill;
        to_cnt_nxt     = to_cnt;
        ld_instr       = 1'b0;
        bus_err_nxt    = bus_err;

        case (state)
            BOOT: begin
                state_nxt      = FETCH;
                pc_nxt         = redir ? redir_target : pc;
                fetch_addr_nxt = pc_nxt;
                kill_nxt       = 1'b0;
                to_cnt_nxt     = '0;
            end

            FETCH: begin
                if (bus.imem_ack) begin
                    to_cnt_nxt = '0;
                    if (redir) begin
                        // Data arriving with a redirect is stale; refetch from the target.
                        pc_nxt         = redir_target;
                        fetch_addr_nxt = redir_target;
                        kill_nxt       = 1'b0;
                    end else if (kill) begin
                        kill_nxt       = 1'b0;
                        fetch_addr_nxt = pc;
                    end else begin
                        ld_instr  = 1'b1;
                        pc_nxt    = fetch_addr + 32'd4;
                        state_nxt = HOLD;
                    end
                end else if (to_expire) begin
                    state_nxt   = ERR;
                    bus_err_nxt = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                    // The request address must stay put, so remember to drop its data instead.
                    if (redir) begin
                        pc_nxt   = redir_target;
                        kill_nxt = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (redir) begin
                    pc_nxt         = redir_target;
                    fetch_addr_nxt = redir_target;
                    to_cnt_nxt     = '0;
                    state_nxt      = FETCH;
                end else if (bus.dec_ready) begin
                    fetch_addr_nxt = pc;
                    to_cnt_nxt     = '0;
                    state_nxt      = FETCH;
                end
            end

            ERR: begin
                state_nxt = ERR;
            end

            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge PcReSet) begin
        if (PcReSet) begin
            pc          <= RESET_PC;
            fetch_addr  <= '0;
            kill        <= 1'b0;
            to_cnt      <= '0;
            instr_out_r <= '0;
            instr_pc_r  <= '0;
            bus_err     <= 1'b0;
            align_err   <= 1'b0;
        end else begin
            pc         <= pc_nxt;
            fetch_addr <= fetch_addr_nxt;
            kill       <= kill_nxt;
            to_cnt     <= to_cnt_nxt;
            bus_err    <= bus_err_nxt;
            align_err  <= align_err_nxt;
            if (ld_instr) begin
                instr_out_r <= bus.imem_rdata;
                instr_pc_r  <= fetch_addr;
            end
        end
    end

    assign bus.imem_req    = (state == FETCH);
    assign bus.imem_addr   = (state == FETCH) ? fetch_addr : 32'd0;
    assign bus.instr_valid = (state == HOLD);
    assign bus.instr_out   = instr_out_r;
    assign bus.instr_pc    = instr_pc_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential fetch, decode stall, redirects, timeout.
module tb_fetch_sequencer;

    logic        Clk;
    logic        PcReSet;
    logic [31:0] ex_pc;
    logic        br_taken;
    logic [15:0] br_off;
    logic        j_valid;
    logic [25:0] j_index;
    logic        jr_valid;
    logic [31:0] jr_addr;
    logic        align_err;
    logic        bus_err;

    int n_checks;
    int n_pass;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .RESET_PC (32'h0000_3000),
        .TIMEOUT  (16),
        .TO_W     (8)
    ) dut (
        .Clk       (Clk),
        .PcReSet   (PcReSet),
        .bus       (bus),
        .ex_pc     (ex_pc),
        .br_taken  (br_taken),
        .br_off    (br_off),
        .j_valid   (j_valid),
        .j_index   (j_index),
        .jr_valid  (jr_valid),
        .jr_addr   (jr_addr),
        .align_err (align_err),
        .bus_err   (bus_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        int n;
        n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        ok = (bus.imem_req === 1'b1);
    endtask

    // Answer the pending request after 'waits' idle cycles.
    task automatic serve(input logic [31:0] data, input int waits);
        for (int i = 0; i < waits; i++) step();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        step();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        PcReSet = 1'b1;
        step();
        step();
        n_checks++;
        if ({bus.imem_req, bus.instr_valid, align_err, bus_err} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {bus.imem_req, bus.instr_valid, align_err, bus_err});
        else n_pass++;
        n_checks++;
        if ({bus.imem_addr, bus.instr_out, bus.instr_pc} !== 96'h0)
            $display("FAIL reset_data: addr=%h out=%h pc=%h expected all 0",
                     bus.imem_addr, bus.instr_out, bus.instr_pc);
        else n_pass++;
        PcReSet = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] addrs [3];
        logic [31:0] words [3];
        bit ok;
        addrs = '{32'h0000_3000, 32'h0000_3004, 32'h0000_3008};
        words = '{32'h2408_0001, 32'h2409_0002, 32'h012A_5820};
        bus.dec_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_req(ok);
            n_checks++;
            if (!ok) $display("FAIL seq_req%0d: imem_req never rose", k);
            else n_pass++;
            n_checks++;
            if (bus.imem_addr !== addrs[k])
                $display("FAIL seq_addr%0d: got %h expected %h", k, bus.imem_addr, addrs[k]);
            else n_pass++;
            serve(words[k], 1);
            n_checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_out !== words[k] || bus.instr_pc !== addrs[k])
                $display("FAIL seq_instr%0d: valid=%b out=%h pc=%h expected 1 %h %h",
                         k, bus.instr_valid, bus.instr_out, bus.instr_pc, words[k], addrs[k]);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_stall();
        bit ok;
        wait_req(ok);
        n_checks++;
        if (!ok || bus.imem_addr !== 32'h0000_300C)
            $display("FAIL stall_addr: got %h expected 0000300c", bus.imem_addr);
        else n_pass++;
        bus.dec_ready = 1'b0;
        serve(32'hAAAA_0001, 0);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0 ||
                bus.instr_out !== 32'hAAAA_0001 || bus.instr_pc !== 32'h0000_300C)
                $display("FAIL stall_hold%0d: valid=%b req=%b out=%h expected 1 0 aaaa0001",
                         i, bus.instr_valid, bus.imem_req, bus.instr_out);
            else n_pass++;
            step();
        end
        bus.dec_ready = 1'b1;
        step();
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_3010 || bus.instr_valid !== 1'b0)
            $display("FAIL stall_release: req=%b addr=%h valid=%b expected 1 00003010 0",
                     bus.imem_req, bus.imem_addr, bus.instr_valid);
        else n_pass++;
    endtask

    task automatic test_branch_kill();
        // 0x3010 + 4 + (-2 << 2) = 0x300C
        bus.dec_ready = 1'b0;
        ex_pc    = 32'h0000_3010;
        br_off   = 16'hFFFE;
        br_taken = 1'b1;
        step();
        br_taken = 1'b0;
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_3010)
            $display("FAIL br_addr_stable: req=%b addr=%h expected 1 00003010",
                     bus.imem_req, bus.imem_addr);
        else n_pass++;
        serve(32'hDEAD_BEEF, 1);
        n_checks++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_300C)
            $display("FAIL br_kill: valid=%b req=%b addr=%h expected 0 1 0000300c",
                     bus.instr_valid, bus.imem_req, bus.imem_addr);
        else n_pass++;
        serve(32'h1111_2222, 1);
        n_checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0000_300C || bus.instr_out !== 32'h1111_2222)
            $display("FAIL br_refetch: valid=%b pc=%h out=%h expected 1 0000300c 11112222",
                     bus.instr_valid, bus.instr_pc, bus.instr_out);
        else n_pass++;
    endtask

    task automatic test_jr_priority();
        // In HOLD with decode also ready: jr must win over br and over the handshake.
        ex_pc         = 32'h0000_3010;
        br_off        = 16'h0010;
        br_taken      = 1'b1;
        jr_valid      = 1'b1;
        jr_addr       = 32'h0000_4002;
        bus.dec_ready = 1'b1;
        step();
        br_taken = 1'b0;
        jr_valid = 1'b0;
        n_checks++;
        if (align_err !== 1'b1)
            $display("FAIL jr_align_pulse: got %b expected 1", align_err);
        else n_pass++;
        n_checks++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_4000)
            $display("FAIL jr_target: valid=%b req=%b addr=%h expected 0 1 00004000",
                     bus.instr_valid, bus.imem_req, bus.imem_addr);
        else n_pass++;
        step();
        n_checks++;
        if (align_err !== 1'b0 || bus.imem_addr !== 32'h0000_4000)
            $display("FAIL jr_align_clear: align=%b addr=%h expected 0 00004000",
                     align_err, bus.imem_addr);
        else n_pass++;
        serve(32'h3333_4444, 0);
        n_checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0000_4000 || bus.instr_out !== 32'h3333_4444)
            $display("FAIL jr_fetch: valid=%b pc=%h out=%h expected 1 00004000 33334444",
                     bus.instr_valid, bus.instr_pc, bus.instr_out);
        else n_pass++;
        step();
    endtask

    task automatic test_jump_with_ack();
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_4004)
            $display("FAIL j_pre_addr: req=%b addr=%h expected 1 00004004", bus.imem_req, bus.imem_addr);
        else n_pass++;
        // {(0x3020+4)[31:28], 0x100, 2'b00} = 0x400, with the ack in the same cycle
        ex_pc          = 32'h0000_3020;
        j_index        = 26'h000_0100;
        j_valid        = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBAD0_BAD0;
        step();
        j_valid      = 1'b0;
        bus.imem_ack = 1'b0;
        n_checks++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_0400)
            $display("FAIL j_target: valid=%b req=%b addr=%h expected 0 1 00000400",
                     bus.instr_valid, bus.imem_req, bus.imem_addr);
        else n_pass++;
        serve(32'h5555_6666, 2);
        n_checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0000_0400 || bus.instr_out !== 32'h5555_6666)
            $display("FAIL j_fetch: valid=%b pc=%h out=%h expected 1 00000400 55556666",
                     bus.instr_valid, bus.instr_pc, bus.instr_out);
        else n_pass++;
        step();
    endtask

    task automatic test_timeout();
        int  n;
        bit  ok;
        n = 0;
        while (bus.imem_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        n_checks++;
        if (n !== 16)
            $display("FAIL to_req_cycles: got %0d expected 16", n);
        else n_pass++;
        n_checks++;
        if (bus_err !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0)
            $display("FAIL to_err_state: bus_err=%b req=%b valid=%b expected 1 0 0",
                     bus_err, bus.imem_req, bus.instr_valid);
        else n_pass++;
        jr_valid = 1'b1;
        jr_addr  = 32'h0000_5001;
        step();
        jr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus_err !== 1'b1 || bus.imem_req !== 1'b0 || align_err !== 1'b0)
                $display("FAIL to_ignore%0d: bus_err=%b req=%b align=%b expected 1 0 0",
                         i, bus_err, bus.imem_req, align_err);
            else n_pass++;
            step();
        end
        PcReSet = 1'b1;
        #2;
        n_checks++;
        if (bus_err !== 1'b0 || bus.imem_req !== 1'b0)
            $display("FAIL to_reset_async: bus_err=%b req=%b expected 0 0", bus_err, bus.imem_req);
        else n_pass++;
        step();
        PcReSet = 1'b0;
        wait_req(ok);
        n_checks++;
        if (!ok || bus.imem_addr !== 32'h0000_3000)
            $display("FAIL to_recover: req=%b addr=%h expected 1 00003000", bus.imem_req, bus.imem_addr);
        else n_pass++;
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        PcReSet        = 1'b1;
        ex_pc          = 32'h0;
        br_taken       = 1'b0;
        br_off         = 16'h0;
        j_valid        = 1'b0;
        j_index        = 26'h0;
        jr_valid       = 1'b0;
        jr_addr        = 32'h0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.dec_ready  = 1'b0;
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_branch_kill();
        test_jr_priority();
        test_jump_with_ack();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
